// File: rtl/control_pulsador_pkg.sv
// Shared event codes, FSM state encoding and width helper for the button event sequencer.
package control_pulsador_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StLongWait,
        StRepeat
    } state_e;

    // One tick counter serves all three hold phases, so size it for the largest limit.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/gen_tick.sv
// Free-running prescaler: pulses tick once every TICK_DIV cycles, restartable via clr.
module gen_tick #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV) + 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] pre_q, pre_d;

    always_comb begin
        tick  = ~clr & (pre_q == LAST);
        pre_d = pre_q + W'(1);
        if (clr || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/control_pulsador.sv
// Button event sequencer: turns a debounced level into PRESS/RELEASE/LONG/REPEAT events
// delivered over a single-entry valid/ready output register.
module control_pulsador
    import control_pulsador_pkg::*;
#(
    parameter int unsigned TICK_DIV         = 100000,
    parameter int unsigned LONG_TICKS       = 1000,
    parameter int unsigned REP_DELAY_TICKS  = 500,
    parameter int unsigned REP_PERIOD_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_in,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       pressed,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int unsigned CW = cnt_width(LONG_TICKS, REP_DELAY_TICKS, REP_PERIOD_TICKS);
    localparam logic [CW-1:0] LONG_TERM   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DELAY_TERM  = CW'(REP_DELAY_TICKS - 1);
    localparam logic [CW-1:0] PERIOD_TERM = CW'(REP_PERIOD_TICKS - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        btn_q;
    logic        evt_valid_q, evt_valid_d;
    logic [1:0]  evt_code_q, evt_code_d;
    logic        ovf_q, ovf_d;

    logic        rise, fall, tick, tick_clr;
    logic        new_evt, load_ok;
    logic [1:0]  new_code;
    logic [CW-1:0] term;

    assign rise     = btn_in & ~btn_q;
    assign fall     = ~btn_in & btn_q;
    // Restarting the prescaler on rise aligns every hold deadline to the PRESS edge.
    assign tick_clr = rise | ~en;

    gen_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_gen_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_evt  = 1'b0;
        new_code = EVT_PRESS;
        case (state_q)
            StHeld:     term = LONG_TERM;
            StLongWait: term = DELAY_TERM;
            default:    term = PERIOD_TERM;
        endcase

        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StIdle) begin
            if (rise) begin
                new_evt  = 1'b1;
                new_code = EVT_PRESS;
                state_d  = StHeld;
                cnt_d    = '0;
            end
        end else if (fall) begin
            // Release outranks any timer expiry in the same cycle.
            new_evt  = 1'b1;
            new_code = EVT_RELEASE;
            state_d  = StIdle;
            cnt_d    = '0;
        end else if (tick) begin
            if (cnt_q == term) begin
                new_evt  = 1'b1;
                new_code = (state_q == StHeld) ? EVT_LONG : EVT_REPEAT;
                state_d  = (state_q == StHeld) ? StLongWait : StRepeat;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        load_ok     = ~evt_valid_q | evt_ready;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        if (new_evt && load_ok) begin
            evt_valid_d = 1'b1;
            evt_code_d  = new_code;
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
        ovf_d = (new_evt & ~load_ok) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            btn_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_PRESS;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_q       <= btn_in;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign pressed   = btn_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_control_pulsador.sv
// Directed scenarios plus a random phase, checked against a hold-time based event model.
module tb_control_pulsador;

    localparam int TD  = 4;
    localparam int LT  = 5;
    localparam int RDT = 3;
    localparam int RPT = 2;
    localparam int LD  = LT * TD;
    localparam int RDD = RDT * TD;
    localparam int RPD = RPT * TD;

    localparam logic [1:0] C_PRESS   = 2'b00;
    localparam logic [1:0] C_RELEASE = 2'b01;
    localparam logic [1:0] C_LONG    = 2'b10;
    localparam logic [1:0] C_REPEAT  = 2'b11;

    logic       clk = 1'b0;
    logic       rst, en, btn_in, evt_ready, ovf_clr;
    logic       evt_valid, pressed, ovf;
    logic [1:0] evt_code;

    control_pulsador #(
        .TICK_DIV         (TD),
        .LONG_TICKS       (LT),
        .REP_DELAY_TICKS  (RDT),
        .REP_PERIOD_TICKS (RPT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .btn_in    (btn_in),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .pressed   (pressed),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: event times derived from cycles held since the PRESS edge.
    bit       m_btn, m_active, m_valid, m_ovf;
    int       m_age;
    bit [1:0] m_code;

    int       log_cyc[$];
    bit [1:0] log_code[$];

    task automatic model_reset();
        m_btn = 0; m_active = 0; m_valid = 0; m_ovf = 0; m_age = 0; m_code = 2'b00;
    endtask

    task automatic model_edge();
        bit rise, fall, evt, load_ok;
        bit [1:0] code;
        rise = btn_in && !m_btn;
        fall = !btn_in && m_btn;
        evt = 0;
        code = C_PRESS;
        if (!en) begin
            m_active = 0;
        end else if (!m_active) begin
            if (rise) begin evt = 1; code = C_PRESS; m_active = 1; m_age = 0; end
        end else if (fall) begin
            evt = 1; code = C_RELEASE; m_active = 0;
        end else begin
            m_age++;
            if (m_age == LD) begin
                evt = 1; code = C_LONG;
            end else if (m_age >= LD + RDD && (m_age - LD - RDD) % RPD == 0) begin
                evt = 1; code = C_REPEAT;
            end
        end
        load_ok = !m_valid || evt_ready;
        m_ovf = (evt && !load_ok) || (m_ovf && !ovf_clr);
        if (evt && load_ok) begin
            m_valid = 1; m_code = code;
        end else if (evt_ready) begin
            m_valid = 0;
        end
        m_btn = btn_in;
    endtask

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        if (evt_valid) begin
            log_cyc.push_back(cyc);
            log_code.push_back(evt_code);
        end
        chk("outputs", {evt_valid, evt_code, pressed, ovf}, {m_valid, m_code, m_btn, m_ovf});
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_code.delete();
    endtask

    task automatic expect_evt(string tag, int idx, int exp_cyc, bit [1:0] exp_code);
        int obs;
        obs = (idx < log_cyc.size()) ? (log_cyc[idx] * 4 + int'(log_code[idx])) : -1;
        chk(tag, obs, exp_cyc * 4 + int'(exp_code));
    endtask

    int t0;

    initial begin
        rst = 1; en = 1; btn_in = 1; evt_ready = 1; ovf_clr = 0;
        model_reset();
        #12;
        chk("reset_outputs", {evt_valid, evt_code, pressed, ovf}, 0);
        @(negedge clk);
        rst = 0;

        // Held at reset release: PRESS one edge later, then quiet.
        clear_log();
        t0 = cyc + 1;
        steps(6);
        chk("reset_n_events", log_cyc.size(), 1);
        expect_evt("reset_press", 0, t0, C_PRESS);
        btn_in = 0;
        steps(3);

        // Short press.
        clear_log();
        t0 = cyc + 1;
        btn_in = 1;
        steps(10);
        btn_in = 0;
        steps(3);
        chk("short_n_events", log_cyc.size(), 2);
        expect_evt("short_press", 0, t0, C_PRESS);
        expect_evt("short_release", 1, t0 + 10, C_RELEASE);
        chk("short_ovf", ovf, 0);

        // Long hold for 60+ cycles.
        clear_log();
        t0 = cyc + 1;
        btn_in = 1;
        steps(61);
        btn_in = 0;
        steps(3);
        chk("long_n_events", log_cyc.size(), 7);
        expect_evt("long_press", 0, t0, C_PRESS);
        expect_evt("long_long", 1, t0 + 20, C_LONG);
        expect_evt("long_rep0", 2, t0 + 32, C_REPEAT);
        expect_evt("long_rep1", 3, t0 + 40, C_REPEAT);
        expect_evt("long_rep2", 4, t0 + 48, C_REPEAT);
        expect_evt("long_rep3", 5, t0 + 56, C_REPEAT);
        expect_evt("long_release", 6, t0 + 61, C_RELEASE);

        // Fall in the exact cycle LONG would fire.
        clear_log();
        t0 = cyc + 1;
        btn_in = 1;
        steps(20);
        btn_in = 0;
        steps(4);
        chk("conflict_n_events", log_cyc.size(), 2);
        expect_evt("conflict_press", 0, t0, C_PRESS);
        expect_evt("conflict_release", 1, t0 + 20, C_RELEASE);

        // Backpressure: RELEASE dropped, PRESS held.
        evt_ready = 0;
        btn_in = 1;
        steps(3);
        btn_in = 0;
        steps(3);
        chk("bp_hold", {evt_valid, evt_code, ovf}, 4'b1001);
        evt_ready = 1;
        step();
        chk("bp_accept", evt_valid, 0);
        chk("bp_ovf_sticky", ovf, 1);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        chk("bp_ovf_clr", ovf, 0);

        // Async reset while in REPEAT with a pending event and ovf set.
        evt_ready = 0;
        btn_in = 1;
        steps(40);
        chk("pre_reset_state", {evt_valid, pressed, ovf}, 3'b111);
        #2;
        rst = 1;
        btn_in = 0;
        #1;
        chk("async_reset", {evt_valid, pressed, ovf}, 0);
        #1;
        rst = 0;
        model_reset();
        evt_ready = 1;
        clear_log();
        steps(6);
        chk("post_reset_events", log_cyc.size(), 0);

        // Random phase.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 29) == 0) btn_in = ~btn_in;
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            en        = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pulsador.md
Name: control_pulsador

Overview:
- Button event sequencer placed after the antirebote debouncer.
- Turns one debounced button level into a stream of timed events: PRESS, RELEASE, LONG and auto-REPEAT.
- Each event is delivered through a valid/ready handshake to the consumer (menu FSM or UART reporter).
- All timing derives from a local tick prescaler, so hold times are independent of the consumer.

Parameters:
- TICK_DIV, 100000: clk cycles per timer tick (1 ms at 10 ns period).
- LONG_TICKS, 1000: ticks held after PRESS before LONG is emitted.
- REP_DELAY_TICKS, 500: ticks from LONG to the first REPEAT.
- REP_PERIOD_TICKS, 100: ticks between successive REPEATs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  enable; 0 forces IDLE and suppresses new events
- btn_in  in  1  debounced button level (antirebote btn_out)
- evt_valid  out  1  event pending
- evt_code  out  2  event code: 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready at a clk edge
- pressed  out  1  registered button level as seen by the FSM
- ovf  out  1  sticky: an event was dropped
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (async, immediate): state=IDLE, btn_q=0, prescaler=0, tick counter=0, evt_valid=0, evt_code=00, pressed=0, ovf=0.
- Edge detection: rise = btn_in & ~btn_q; fall = ~btn_in & btn_q. btn_q registers btn_in every cycle. pressed = btn_q.
- Latency: an event generated at edge N is visible (evt_valid=1) after edge N, i.e. 1 cycle after the btn_in change.
- Prescaler: counts 0..TICK_DIV-1 and pulses tick on wrap. It restarts at 0 on rise, so LONG fires exactly LONG_TICKS*TICK_DIV cycles after PRESS.
- FSM states IDLE, HELD, LONG_WAIT, REPEAT:
  - IDLE: on rise, emit PRESS and go to HELD with tick count 0.
  - HELD: count ticks; at LONG_TICKS, emit LONG and go to LONG_WAIT with count 0.
  - LONG_WAIT: at REP_DELAY_TICKS, emit REPEAT and go to REPEAT with count 0.
  - REPEAT: every REP_PERIOD_TICKS, emit REPEAT.
  - HELD, LONG_WAIT, REPEAT: on fall, emit RELEASE and go to IDLE.
- Simultaneous events: fall wins over timer expiry in the same cycle. Only RELEASE is emitted and the timer event is discarded.
- Handshake:
  - A new event loads the output register when evt_valid=0 or evt_ready=1 (accept and load in the same cycle is lossless).
  - evt_valid and evt_code stay stable until accepted.
  - If a new event arrives while evt_valid=1 and evt_ready=0, the new event is dropped, the pending event is kept and ovf is set.
- ovf: set has priority over ovf_clr in the same cycle.
- en=0: FSM goes to IDLE and counters clear; btn_q keeps tracking btn_in, so no spurious PRESS is emitted on re-enable while held. A pending event is still delivered.
- Button held at reset release: btn_q=0, so the first edge emits PRESS.
- Counter widths: $clog2 of each limit plus 1. Terminal-count compares are equality; counters never wrap past a limit.

Decomposition:
- Package control_pulsador_pkg holds the evt_code localparams (EVT_PRESS=2'b00, EVT_RELEASE=2'b01, EVT_LONG=2'b10, EVT_REPEAT=2'b11) and the state encoding.
- One natural sub-module: gen_tick (parameter TICK_DIV; ports clk, rst, clr, tick), reusable by antirebote-style blocks.

Test Plan:
- All scenarios use TICK_DIV=4, LONG_TICKS=5, REP_DELAY_TICKS=3, REP_PERIOD_TICKS=2; evt_ready=1 and en=1 unless stated.
- Reset: rst=1, btn_in=1 -> all outputs 0. Release rst with btn_in held -> PRESS 1 cycle later, then nothing until timers run.
- Short press: btn_in high for 10 cycles -> PRESS at rise+1, RELEASE at fall+1, no LONG, ovf=0.
- Long hold for 60 cycles, PRESS at cycle t -> LONG at t+20, REPEAT at t+32, t+40, t+48, t+56, RELEASE 1 cycle after fall.
- Backpressure:
  - Stimulus: evt_ready=0, short press.
  - Response: evt_valid=1 with code 00 held stable, RELEASE dropped, ovf=1.
  - Then evt_ready=1 for 1 cycle -> evt_valid=0.
  - Then ovf_clr pulse -> ovf=0.
- Conflict: fall lands in the exact cycle LONG would fire (t+20) -> only RELEASE is seen, never LONG.
- Async reset mid-REPEAT: rst pulsed between clk edges -> evt_valid, pressed and ovf go 0 immediately, and after release the FSM is IDLE with no event.
